// File: rtl/bwn_pe_ctrl.sv
// Sequencer for a binary-weight PE array. It streams one input vector to all PEs,
// captures their results and drains them one word at a time over a valid/ready port.
module bwn_pe_ctrl #(
    parameter int INPUT_SIZE = 226,
    parameter int NUM_PE     = 8,
    parameter int D_WL       = 16,
    parameter int AW         = 8,
    localparam int IW        = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   rd_en,
    output logic [AW-1:0]          rd_addr,
    output logic                   pe_in_valid,
    input  logic                   pe_ready,
    input  logic                   pe_o_valid,
    input  logic [NUM_PE*D_WL-1:0] pe_d,
    output logic [D_WL-1:0]        out_data,
    output logic [IW-1:0]          out_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [7:0]             pass_cnt
);

    // state | meaning
    // IDLE  | waiting for start with PE0 ready
    // FEED  | issuing INPUT_SIZE memory reads
    // WAIT  | waiting for PE o_valid, bounded by a timeout
    // DRAIN | presenting buffered results, one per handshake
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DRAIN} state_t;

    localparam logic [AW-1:0] ADDR_LAST = AW'(INPUT_SIZE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_PE - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic            in_valid_q;
    logic [1:0]      tmr_q;
    logic [IW-1:0]   idx_q;
    logic [D_WL-1:0] buf_q [NUM_PE];
    logic [7:0]      pass_q;
    logic            done_q;
    logic            err_q;
    logic            capture;
    logic            timeout;
    logic            last_hs;

    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        last_hs   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && pe_ready) state_d = S_FEED;
            end
            S_FEED: begin
                rd_en = 1'b1;
                if (addr_q == ADDR_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pe_o_valid) begin
                    capture = 1'b1;
                    state_d = S_DRAIN;
                end else if (!in_valid_q && tmr_q == 2'd1) begin
                    timeout = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && idx_q == IDX_LAST) begin
                    last_hs = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            in_valid_q <= 1'b0;
            tmr_q      <= 2'd3;
            idx_q      <= '0;
            pass_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_valid_q <= rd_en;
            done_q     <= last_hs;
            if (state_q == S_FEED && addr_q != ADDR_LAST) addr_q <= addr_q + 1'b1;
            else                                          addr_q <= '0;
            // Timeout window opens once the last in_valid has gone by.
            if (state_q != S_WAIT)               tmr_q <= 2'd3;
            else if (!in_valid_q && !pe_o_valid) tmr_q <= tmr_q - 2'd1;
            if (out_valid && out_ready) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            if (last_hs) pass_q <= pass_q + 8'd1;
            if (timeout || (pe_o_valid && (state_q == S_FEED || in_valid_q))) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PE; i++) buf_q[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_PE; i++) buf_q[i] <= pe_d[i*D_WL +: D_WL];
        end
    end

    assign rd_addr     = addr_q;
    assign pe_in_valid = in_valid_q;
    assign out_data    = out_valid ? buf_q[idx_q] : '0;
    assign out_idx     = idx_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign pass_cnt    = pass_q;

endmodule

// File: tb/tb_bwn_pe_ctrl.sv
// Bench for bwn_pe_ctrl with INPUT_SIZE=4, NUM_PE=2: memory and binary-weight PE
// models attached, table vectors, random passes and hand-written corner sequences.
module tb_bwn_pe_ctrl;

    localparam int N  = 4;
    localparam int NP = 2;
    localparam int DW = 16;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic            pe_in_valid;
    logic            pe_ready;
    logic            pe_o_valid;
    logic [NP*DW-1:0] pe_d;
    logic [DW-1:0]   out_data;
    logic [0:0]      out_idx;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            busy, done, err;
    logic [7:0]      pass_cnt;

    bwn_pe_ctrl #(.INPUT_SIZE(N), .NUM_PE(NP), .D_WL(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .pe_in_valid(pe_in_valid), .pe_ready(pe_ready), .pe_o_valid(pe_o_valid),
        .pe_d(pe_d), .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // Memories and PE array model: PE i adds x when its weight bit is 0, subtracts when 1.
    logic [15:0]        x_mem [N];
    logic [1:0]         w_mem [N];
    logic [15:0]        x_q;
    logic [1:0]         w_q;
    logic [2:0]         cnt;
    logic [NP-1:0][15:0] acc, nacc, res;
    logic               ov_q;
    logic               kill_ov = 1'b0;
    logic               ready_block = 1'b0;

    always_comb begin
        nacc = acc;
        for (int i = 0; i < NP; i++) nacc[i] = w_q[i] ? acc[i] - x_q : acc[i] + x_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0; w_q <= '0; cnt <= '0; ov_q <= 1'b0; acc <= '0; res <= '0;
        end else begin
            if (rd_en) begin
                x_q <= x_mem[rd_addr[1:0]];
                w_q <= w_mem[rd_addr[1:0]];
            end
            ov_q <= 1'b0;
            if (pe_in_valid) begin
                if (cnt == 3'(N - 1)) begin
                    res <= nacc; acc <= '0; cnt <= '0; ov_q <= 1'b1;
                end else begin
                    acc <= nacc; cnt <= cnt + 3'd1;
                end
            end
        end
    end

    assign pe_o_valid = ov_q & ~kill_ov;
    assign pe_ready   = (cnt == 3'd0) & ~ready_block;
    assign pe_d       = {res[1], res[0]};

    typedef struct packed {
        logic [N-1:0][15:0] x;
        logic [N-1:0][1:0]  w;
        logic [15:0]        e0;
        logic [15:0]        e1;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int exp_passes = 0;
    logic [15:0] last_e0, last_e1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_sum(input vec_t v, input int pe);
        int s = 0;
        for (int k = 0; k < N; k++) s += v.w[k][pe] ? -int'(v.x[k]) : int'(v.x[k]);
        return 16'(s);
    endfunction

    task automatic load(input vec_t v);
        for (int k = 0; k < N; k++) begin
            x_mem[k] = v.x[k];
            w_mem[k] = v.w[k];
        end
    endtask

    // Consume both result words; returns positioned in the done cycle.
    task automatic drain(input logic [15:0] e0, input logic [15:0] e1, input bit stall);
        int k = 0;
        int budget = 0;
        logic [15:0] exp_w;
        while (k < NP && budget < 200) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                exp_w = (k == 0) ? e0 : e1;
                chk("out_idx", 32'(out_idx), 32'(k));
                chk("out_data", 32'(out_data), 32'(exp_w));
                k++;
            end
            tick();
            budget++;
        end
        out_ready = 1'b0;
        if (k < NP) chk("drain_timeout", 32'(k), 32'(NP));
        exp_passes++;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("pass_cnt", 32'(pass_cnt), 32'(exp_passes[7:0]));
        last_e0 = e0;
        last_e1 = e1;
    endtask

    task automatic run_pass(input vec_t v, input bit stall);
        load(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(v.e0, v.e1, stall);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    vec_t tbl [4];
    vec_t rv;
    int   pulses;
    int   guard;
    logic [15:0] hold_d;
    logic [0:0]  hold_i;

    initial begin
        tbl[0] = '{x: {4{16'h1000}}, w: {4{2'b10}}, e0: 16'h4000, e1: 16'hC000};
        tbl[1] = '{x: {16'd4, 16'd3, 16'd2, 16'd1}, w: {4{2'b00}}, e0: 16'h000A, e1: 16'h000A};
        tbl[2] = '{x: {16'd4, 16'd3, 16'd2, 16'd1}, w: {2'b10, 2'b01, 2'b10, 2'b01},
                   e0: 16'h0002, e1: 16'hFFFE};
        tbl[3] = '{x: {16'h0000, 16'h0001, 16'h8000, 16'h8000}, w: {4{2'b11}},
                   e0: 16'hFFFF, e1: 16'hFFFF};

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {rd_en, pe_in_valid, out_valid, done, err}, 32'd0);
        chk("rst_vals", {rd_addr, out_data, pass_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Cycle-exact first pass using the x=1.0 vector.
        load(tbl[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("c%0d_rd_en", c), 32'(rd_en), 32'(c <= 4));
            if (c <= 5) chk($sformatf("c%0d_rd_addr", c), 32'(rd_addr), (c <= 4) ? 32'(c - 1) : 32'd0);
            chk($sformatf("c%0d_in_valid", c), 32'(pe_in_valid), 32'(c >= 2 && c <= 5));
            chk($sformatf("c%0d_o_valid", c), 32'(pe_o_valid), 32'(c == 6));
            chk($sformatf("c%0d_out_valid", c), 32'(out_valid), 32'(c == 7));
            if (c < 7) tick();
        end
        drain(tbl[0].e0, tbl[0].e1, 1'b0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);

        for (int t = 0; t < 4; t++) run_pass(tbl[t], 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < N; k++) begin
                rv.x[k] = 16'($urandom_range(0, 16'hFFFF));
                rv.w[k] = 2'($urandom_range(0, 3));
            end
            rv.e0 = ref_sum(rv, 0);
            rv.e1 = ref_sum(rv, 1);
            run_pass(rv, 1'b1);
        end

        // Downstream stall: outputs hold and no done until both handshakes.
        load(tbl[2]);
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin tick(); guard++; end
        chk("stall_reach_drain", 32'(out_valid), 32'd1);
        hold_d = out_data;
        hold_i = out_idx;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("stall_data", 32'(out_data), 32'(tbl[2].e0));
            chk("stall_stable", {out_data, 15'd0, out_idx}, {hold_d, 15'd0, hold_i});
            chk("stall_no_done", 32'(done), 32'd0);
        end
        drain(tbl[2].e0, tbl[2].e1, 1'b0);
        tick();

        // Start held through FEED is ignored; exactly four in_valid pulses.
        load(tbl[1]);
        start = 1'b1;
        tick();
        pulses = 0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            if (guard == 3) start = 1'b0;
            pulses += int'(pe_in_valid);
            tick();
            guard++;
        end
        start = 1'b0;
        chk("in_valid_pulses", 32'(pulses), 32'd4);
        drain(tbl[1].e0, tbl[1].e1, 1'b0);
        tick();

        // Start with PE not ready is ignored.
        ready_block = 1'b1;
        start = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("notready_busy", 32'(busy), 32'd0);
            chk("notready_rd_en", 32'(rd_en), 32'd0);
        end
        start = 1'b0;
        ready_block = 1'b0;
        tick();
        chk("err_clean", 32'(err), 32'd0);

        // Missing o_valid: err on 4th cycle after last in_valid, buffer unchanged.
        kill_ov = 1'b1;
        load(tbl[3]);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("tmo_err_c8", 32'(err), 32'd0);
        chk("tmo_wait_c8", 32'(out_valid), 32'd0);
        tick();
        chk("tmo_err_c9", 32'(err), 32'd1);
        chk("tmo_drain_c9", 32'(out_valid), 32'd1);
        drain(last_e0, last_e1, 1'b0);
        kill_ov = 1'b0;
        chk("err_sticky", 32'(err), 32'd1);
        tick();

        // Reset mid-FEED.
        load(tbl[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("feed_before_rst", 32'(rd_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {rd_en, pe_in_valid, out_valid, busy, done, err}, 32'd0);
        chk("mid_rst_vals", {rd_addr, out_idx, out_data, pass_cnt}, 32'd0);
        exp_passes = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // 256 back-to-back passes, each started in the previous done cycle.
        load(tbl[1]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 256; p++) begin
            drain(tbl[1].e0, tbl[1].e1, 1'b0);
            if (p < 255) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("done_cycle_start", 32'(busy), 32'd1);
            end
        end
        chk("pass_cnt_wrap", 32'(pass_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
